grv_sample_serializer: RTL

//  Downstream stage of the Box-Muller Gaussian generator. Captures each (grv1, grv2) pair on its valid pulse,

---
 rtl/grv_pkg.sv | 26 ++
 rtl/grv_sample_serializer_if.sv | 23 ++
 rtl/grv_pair_fifo.sv | 50 +++++
 rtl/grv_sample_serializer.sv | 131 +++++++++++++
 4 files changed

// File: rtl/grv_pkg.sv
// Shared types and helpers for the Gaussian sample serializer.
// Sign-magnitude to two's-complement conversion lives here so every stage agrees on it.
package grv_pkg;

    localparam int GRV_W     = 16;
    localparam int GRV_MAG_W = 11;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EMIT_A = 2'd1,
        EMIT_B = 2'd2
    } ser_state_t;

    typedef struct packed {
        logic [GRV_W-1:0] grv1;
        logic [GRV_W-1:0] grv2;
    } grv_pair_t;

    // Bits between the sign and the magnitude are don't-care; a negative zero maps to zero.
    function automatic logic [GRV_W-1:0] sm_to_tc(input logic [GRV_W-1:0] x);
        logic [GRV_W-1:0] mag;
        mag = {{(GRV_W-GRV_MAG_W){1'b0}}, x[GRV_MAG_W-1:0]};
        return x[GRV_W-1] ? (-mag) : mag;
    endfunction

endpackage

// File: rtl/grv_sample_serializer_if.sv
// Generator-side pair input and consumer-side valid/ready sample output of the serializer.
// Signal suffixes are from the serializer's point of view (slave modport).
interface grv_sample_serializer_if;

    logic        pair_valid_i;
    logic [15:0] grv1_i;
    logic [15:0] grv2_i;
    logic [15:0] sample_o;
    logic        sample_valid_o;
    logic        sample_ready_i;
    logic        sample_sel_o;

    modport slave (
        input  pair_valid_i, grv1_i, grv2_i, sample_ready_i,
        output sample_o, sample_valid_o, sample_sel_o
    );

    modport master (
        output pair_valid_i, grv1_i, grv2_i, sample_ready_i,
        input  sample_o, sample_valid_o, sample_sel_o
    );

endinterface

// File: rtl/grv_pair_fifo.sv
// DEPTH-entry FIFO of raw (grv1, grv2) pairs; combinational read of the head entry.
// DEPTH must be a power of two so the pointers wrap naturally.
module grv_pair_fifo #(
    parameter int DEPTH = 4,
    parameter int LVL_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic [31:0]      wdata_i,
    input  logic             pop_i,
    output logic [31:0]      rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [LVL_W-1:0] level_o
);

    localparam int PW = $clog2(DEPTH);

    logic [31:0]      mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    rd_ptr_q;
    logic [LVL_W-1:0] level_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push_i, pop_i})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign full_o  = (level_q == LVL_W'(DEPTH));
    assign empty_o = (level_q == '0);
    assign level_o = level_q;

endmodule

// File: rtl/grv_sample_serializer.sv
// Buffers Box-Muller pairs and emits them one two's-complement sample per valid/ready handshake.
// Optional GRV_OVF_COUNT_EN adds a saturating dropped-pair counter on ovf_count_o.
module grv_sample_serializer
    import grv_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int LVL_W = 3
) (
    input  logic                     clk,
    input  logic                     reset,
    grv_sample_serializer_if.slave   bus,
    output logic [LVL_W-1:0]         fifo_level_o,
    output logic                     overflow_o,
    input  logic                     clr_ovf_i
`ifdef GRV_OVF_COUNT_EN
    ,
    output logic [15:0]              ovf_count_o
`endif
);

    ser_state_t       state_q;
    logic [GRV_W-1:0] sample_q;
    logic             valid_q;
    logic             sel_q;
    logic [GRV_W-1:0] hold_q;
    logic             ovf_q;

    grv_pair_t        rd_pair;
    logic [31:0]      rd_data;
    logic             fifo_full;
    logic             fifo_empty;
    logic             hs;
    logic             pop;
    logic             push;
    logic             drop;

    assign hs   = valid_q && bus.sample_ready_i;
    assign pop  = !fifo_empty && ((state_q == IDLE) || ((state_q == EMIT_B) && hs));
    // A full FIFO still accepts when its head leaves in the same cycle.
    assign push = bus.pair_valid_i && (!fifo_full || pop);
    assign drop = bus.pair_valid_i && !push;
    assign rd_pair = grv_pair_t'(rd_data);

    grv_pair_fifo #(.DEPTH(DEPTH), .LVL_W(LVL_W)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push),
        .wdata_i ({bus.grv1_i, bus.grv2_i}),
        .pop_i   (pop),
        .rdata_o (rd_data),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (fifo_level_o)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            sample_q <= '0;
            valid_q  <= 1'b0;
            sel_q    <= 1'b0;
            hold_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pop) begin
                        sample_q <= sm_to_tc(rd_pair.grv1);
                        hold_q   <= rd_pair.grv2;
                        valid_q  <= 1'b1;
                        sel_q    <= 1'b0;
                        state_q  <= EMIT_A;
                    end
                end
                EMIT_A: begin
                    if (hs) begin
                        sample_q <= sm_to_tc(hold_q);
                        sel_q    <= 1'b1;
                        state_q  <= EMIT_B;
                    end
                end
                EMIT_B: begin
                    if (hs) begin
                        if (pop) begin
                            sample_q <= sm_to_tc(rd_pair.grv1);
                            hold_q   <= rd_pair.grv2;
                            sel_q    <= 1'b0;
                            state_q  <= EMIT_A;
                        end else begin
                            valid_q  <= 1'b0;
                            state_q  <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // A drop in the same cycle as a clear leaves the flag set.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ovf_q <= 1'b0;
        end else if (drop) begin
            ovf_q <= 1'b1;
        end else if (clr_ovf_i) begin
            ovf_q <= 1'b0;
        end
    end

`ifdef GRV_OVF_COUNT_EN
    logic [15:0] ovf_cnt_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ovf_cnt_q <= '0;
        end else if (clr_ovf_i) begin
            ovf_cnt_q <= '0;
        end else if (drop && (ovf_cnt_q != 16'hFFFF)) begin
            ovf_cnt_q <= ovf_cnt_q + 16'd1;
        end
    end

    assign ovf_count_o = ovf_cnt_q;
`endif

    assign bus.sample_o       = sample_q;
    assign bus.sample_valid_o = valid_q;
    assign bus.sample_sel_o   = sel_q;
    assign overflow_o         = ovf_q;

endmodule
